fifo_push_arbiter: RTL and testbench

- Shares the single push port of the parity-checked FIFO (`top`) between N_REQ producers.
- Each producer uses the codebase valid/grant handshake. The block picks one producer with a round-robin rule and holds it for a burst of up to MAX_BURST beats.
- Data goes through one output register with no change, so the parity bit from the producer reaches the FIFO as sent.
- Sits between the producer agents and the `data_i`/`valid_i`/`grant_o` ports of the FIFO.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/fifo_push_arbiter_picker.sv | 43 ++++
 rtl/fifo_push_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fifo_push_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-port arbiter.
//   arb_state_t : arbiter state (IDLE searches for a new owner, BURST holds one).
//   rr_next     : round-robin successor of an index, modulo the requester count.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Next round-robin index; n_req need not be a power of two.
    function automatic int rr_next(input int idx, input int n_req);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n_req) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_picker.sv
// Round-robin search: returns the first requester with valid set, scanning
// upward from rr_ptr_i with wrap-around modulo N_REQ.
//   req_valid_i : per-requester valid flags
//   rr_ptr_i    : index where the search starts (always < N_REQ)
//   sel_o       : selected index (0 when nothing is valid)
//   any_valid_o : at least one requester is valid
module fifo_rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] sel_o,
    output logic             any_valid_o
);

    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam int IW1 = IDX_W + 1;

    logic [IW1-1:0] w_idx;

    // Priority scan starting at rr_ptr_i; the first hit wins.
    always_comb begin
        sel_o       = '0;
        any_valid_o = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, rr_ptr_i} + IW1'(i);
            if (w_idx >= IW1'(N_REQ)) begin
                w_idx = w_idx - IW1'(N_REQ);
            end else begin
                w_idx = w_idx;
            end
            if (!any_valid_o && req_valid_i[w_idx[IDX_W-1:0]]) begin
                sel_o       = w_idx[IDX_W-1:0];
                any_valid_o = 1'b1;
            end else begin
                sel_o       = sel_o;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares the single push port of the parity-checked FIFO between N_REQ
// producers. A round-robin pick selects an owner, which then keeps the port
// for up to MAX_BURST beats. Words pass unchanged (parity bit included)
// through one output register.
//   clk, rst    : clock, synchronous active-high reset
//   req_data_i  : packed words, requester k at [k*W +: W]
//   req_valid_i : requester k has a word
//   req_grant_o : one-hot/zero, requester k's word is accepted this cycle
//   data_o      : word towards FIFO data_i
//   valid_o     : towards FIFO valid_i
//   grant_i     : from FIFO grant_o
//   owner_o     : requester whose word sits in data_o
//   active_o    : arbiter is in BURST
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 4,
    localparam int W          = DATA_WIDTH + 1,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ*W-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    output logic [N_REQ-1:0]   req_grant_o,
    output logic [W-1:0]       data_o,
    output logic               valid_o,
    input  logic               grant_i,
    output logic [IDX_W-1:0]   owner_o,
    output logic               active_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [IDX_W-1:0] r_owner;

    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic [IDX_W-1:0] w_gidx;
    logic [N_REQ-1:0] w_grant;
    logic             w_out_rdy;
    logic             w_up;
    logic             w_down;
    logic [W-1:0]     w_word;

    fifo_rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req_valid_i(req_valid_i),
        .rr_ptr_i   (r_rr_ptr),
        .sel_o      (w_sel),
        .any_valid_o(w_any)
    );

    // The output register can take a word when empty or being drained now.
    assign w_out_rdy = !r_valid || grant_i;
    assign w_up      = |(req_valid_i & w_grant);
    assign w_down    = r_valid && grant_i;
    assign w_word    = req_data_i[int'(w_gidx) * W +: W];

    // Grant generation: new pick in IDLE, current owner only in BURST.
    always_comb begin
        w_grant = '0;
        w_gidx  = w_sel;
        case (r_state)
            IDLE: begin
                w_gidx = w_sel;
                if (!rst && w_out_rdy && w_any) begin
                    w_grant[w_sel] = 1'b1;
                end else begin
                    w_grant = '0;
                end
            end
            BURST: begin
                w_gidx = r_owner;
                if (!rst && w_out_rdy && req_valid_i[r_owner]) begin
                    w_grant[r_owner] = 1'b1;
                end else begin
                    w_grant = '0;
                end
            end
            default: begin
                w_gidx  = w_sel;
                w_grant = '0;
            end
        endcase
    end

    // Next state, round-robin pointer and beat counter.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_up) begin
                    w_cnt_nxt = CNT_W'(1);
                    if (MAX_BURST == 1) begin
                        // Single-beat bursts rotate immediately.
                        w_rr_nxt = IDX_W'(rr_next(int'(w_sel), N_REQ));
                    end else begin
                        w_state_nxt = BURST;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BURST: begin
                if (w_out_rdy) begin
                    if (w_up) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
                            w_state_nxt = IDLE;
                            w_rr_nxt    = IDX_W'(rr_next(int'(r_owner), N_REQ));
                        end else begin
                            w_state_nxt = BURST;
                        end
                    end else begin
                        // Owner ran dry (or reset pending): give up the port.
                        w_state_nxt = IDLE;
                        w_rr_nxt    = IDX_W'(rr_next(int'(r_owner), N_REQ));
                    end
                end else begin
                    // Downstream stalled: hold everything regardless of valid.
                    w_state_nxt = BURST;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Arbiter control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Output register: reload on an upstream beat, drain on a downstream beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_owner <= '0;
        end else if (w_up) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_owner <= w_gidx;
        end else if (w_down) begin
            r_valid <= 1'b0;
        end
    end

    assign req_grant_o = w_grant;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign owner_o     = r_owner;
    assign active_o    = (r_state == BURST);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
module tb_fifo_push_arbiter;

    localparam int DW = 32;
    localparam int W  = DW + 1;
    localparam int N0 = 4;
    localparam int N1 = 5;

    typedef struct {
        logic [W-1:0] data;
        int           owner;
        bit           chk_act;
        bit           act;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: 4 requesters, bursts of 4
    logic [N0*W-1:0] req_data0;
    logic [N0-1:0]   req_valid0;
    logic [N0-1:0]   req_grant0;
    logic [W-1:0]    data0;
    logic            valid0;
    logic            grant_i0;
    logic [1:0]      owner0;
    logic            active0;

    // Second instance: 5 requesters (non power of two), single-beat bursts
    logic [N1*W-1:0] req_data1;
    logic [N1-1:0]   req_valid1;
    logic [N1-1:0]   req_grant1;
    logic [W-1:0]    data1;
    logic            valid1;
    logic            grant_i1;
    logic [2:0]      owner1;
    logic            active1;

    fifo_push_arbiter #(.N_REQ(N0), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .req_data_i(req_data0), .req_valid_i(req_valid0),
        .req_grant_o(req_grant0), .data_o(data0), .valid_o(valid0), .grant_i(grant_i0),
        .owner_o(owner0), .active_o(active0)
    );

    fifo_push_arbiter #(.N_REQ(N1), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_data_i(req_data1), .req_valid_i(req_valid1),
        .req_grant_o(req_grant1), .data_o(data1), .valid_o(valid1), .grant_i(grant_i1),
        .owner_o(owner1), .active_o(active1)
    );

    exp_t q0[$];
    exp_t q1[$];
    int   pop_cyc0[$];
    int   pop_cyc1[$];
    int   beats1[N1];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Requester models: word n of requester k is base+n, sends lim words
    int n0[N0], lim0[N0], base0[N0];
    int n1[N1], lim1[N1], base1[N1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(input int v);
        logic [DW-1:0] d;
        d = v[DW-1:0];
        return {^d, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push0(input int owner, input int v, input bit ca, input bit a);
        exp_t e;
        e.data = mk(v); e.owner = owner; e.chk_act = ca; e.act = a;
        q0.push_back(e);
    endtask

    task automatic push1(input int owner, input int v);
        exp_t e;
        e.data = mk(v); e.owner = owner; e.chk_act = 1'b0; e.act = 1'b0;
        q1.push_back(e);
    endtask

    task automatic drive();
        for (int k = 0; k < N0; k++) begin
            req_valid0[k]         = (n0[k] < lim0[k]);
            req_data0[k*W +: W]   = mk(base0[k] + n0[k]);
        end
        for (int k = 0; k < N1; k++) begin
            req_valid1[k]         = (n1[k] < lim1[k]);
            req_data1[k*W +: W]   = mk(base1[k] + n1[k]);
        end
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N0; k++) begin n0[k] = 0; lim0[k] = 0; base0[k] = 0; end
        for (int k = 0; k < N1; k++) begin n1[k] = 0; lim1[k] = 0; base1[k] = 0; end
    endtask

    // One clock: sample accepted words mid-cycle, advance producers after the edge
    task automatic cycle();
        logic [N0-1:0] a0;
        logic [N1-1:0] a1;
        @(negedge clk);
        a0 = req_valid0 & req_grant0;
        a1 = req_valid1 & req_grant1;
        @(posedge clk);
        #1;
        for (int k = 0; k < N0; k++) if (a0[k]) n0[k]++;
        for (int k = 0; k < N1; k++) if (a1[k]) n1[k]++;
        drive();
    endtask

    task automatic wait_q(input int which, input string name);
        for (int i = 0; i < 300 && ((which == 0) ? q0.size() : q1.size()) != 0; i++) cycle();
        chk(name, (which == 0) ? q0.size() : q1.size(), 0);
        repeat (3) cycle();
    endtask

    // Scoreboard monitor for the main instance
    initial begin : mon0
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && valid0 === 1'b1 && grant_i0 === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon0_extra: got word %0d, expected none", data0);
                end else begin
                    e = q0.pop_front();
                    chk("mon0_data", data0, e.data);
                    chk("mon0_owner", owner0, e.owner);
                    if (e.chk_act) chk("mon0_active", active0, e.act);
                    pop_cyc0.push_back(cyc);
                end
            end
        end
    end

    // Scoreboard monitor for the second instance, also counting beats per owner
    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && valid1 === 1'b1 && grant_i1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon1_extra: got word %0d, expected none", data1);
                end else begin
                    e = q1.pop_front();
                    chk("mon1_data", data1, e.data);
                    chk("mon1_owner", owner1, e.owner);
                    if (owner1 < 3'(N1)) beats1[owner1]++;
                    pop_cyc1.push_back(cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; grant_i0 = 1'b1; grant_i1 = 1'b1;
        for (int k = 0; k < N1; k++) beats1[k] = 0;
        clear_reqs();

        // Reset with all producers valid, then four streams of 8 words each
        for (int k = 0; k < N0; k++) begin lim0[k] = 8; base0[k] = k * 100; end
        drive();
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", valid0, 0);
            chk("rst_grant", req_grant0, 0);
            chk("rst_owner", owner0, 0);
            chk("rst_active", active0, 0);
            chk("rst_valid1", valid1, 0);
            chk("rst_grant1", req_grant1, 0);
            @(posedge clk);
            #1;
        end
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N0; k++)
                for (int b = 0; b < 4; b++)
                    push0(k, k * 100 + r * 4 + b, 1'b1, b != 3);
        pop_cyc0.delete();
        rst = 1'b0;
        wait_q(0, "burst_drain");
        if (pop_cyc0.size() == 32)
            chk("burst_no_bubble", pop_cyc0[31] - pop_cyc0[0], 31);
        else
            chk("burst_pop_count", pop_cyc0.size(), 32);

        // Early release: req 2 sends two words and drops, req 3 takes over
        clear_reqs();
        lim0[2] = 2; base0[2] = 500;
        lim0[3] = 2; base0[3] = 600;
        drive();
        push0(2, 500, 1'b0, 1'b0);
        push0(2, 501, 1'b0, 1'b0);
        push0(3, 600, 1'b0, 1'b0);
        push0(3, 601, 1'b0, 1'b0);
        wait_q(0, "early_drain");

        // Backpressure: hold word 701 for five stalled cycles
        clear_reqs();
        lim0[0] = 6; base0[0] = 700;
        drive();
        for (int v = 700; v < 706; v++) push0(0, v, 1'b0, 1'b0);
        cycle();
        cycle();
        grant_i0 = 1'b0;
        repeat (5) begin
            cycle();
            chk("stall_grant", req_grant0, 0);
            chk("stall_data", data0, mk(701));
            chk("stall_valid", valid0, 1);
        end
        grant_i0 = 1'b1;
        wait_q(0, "stall_drain");

        // Wrap and fairness on the 5-requester, single-beat instance
        clear_reqs();
        lim1[2] = 1; base1[2] = 20;
        drive();
        push1(2, 20);
        cycle();
        cycle();
        lim1[1] = 4; base1[1] = 1000;
        lim1[3] = 4; base1[3] = 3000;
        drive();
        for (int i = 0; i < 4; i++) begin
            push1(3, 3000 + i);
            push1(1, 1000 + i);
        end
        pop_cyc1.delete();
        wait_q(1, "wrap_drain");
        if (pop_cyc1.size() == 8)
            chk("wrap_no_bubble", pop_cyc1[7] - pop_cyc1[0], 7);
        else
            chk("wrap_pop_count", pop_cyc1.size(), 8);
        chk("wrap_beats_req1", beats1[1], 4);
        chk("wrap_beats_req3", beats1[3], 4);
        chk("wrap_beats_req2", beats1[2], 1);
        chk("wrap_beats_req0", beats1[0], 0);

        // Mid-burst reset: word 901 in the register is dropped
        clear_reqs();
        lim0[0] = 8; base0[0] = 800;
        lim0[1] = 8; base0[1] = 900;
        drive();
        push0(1, 900, 1'b0, 1'b0);
        cycle();
        cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", req_grant0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", valid0, 0);
        chk("mid_rst_active", active0, 0);
        chk("mid_rst_owner", owner0, 0);
        chk("mid_rst_queue", q0.size(), 0);
        for (int v = 800; v < 804; v++) push0(0, v, 1'b0, 1'b0);
        for (int v = 902; v < 906; v++) push0(1, v, 1'b0, 1'b0);
        for (int v = 804; v < 808; v++) push0(0, v, 1'b0, 1'b0);
        push0(1, 906, 1'b0, 1'b0);
        push0(1, 907, 1'b0, 1'b0);
        wait_q(0, "mid_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
